argmax_classifier: RTL and testbench
====================================

# argmax_classifier

Output classification stage that sits directly downstream of the final `dense_layer`. On each new result it snapshots the layer's output vector and scans it one element per cycle. It then reports the index and value of the largest activation, which is the predicted class. The network top uses this result in place of the raw output vector.

## Interface

**Parameters**
- `NUM_INPUTS`, default 10: number of class scores. Must be ≥ 1.
- `INDEX_WIDTH`, default `$clog2(NUM_INPUTS > 1 ? NUM_INPUTS : 2)`: width of the class index.

**Ports** (clock and reset first)
- `clock`, input, 1: single clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-low. Low at a rising edge resets all state.
- `inputs_ready`, input, 1: connects to the upstream `outputs_ready`. A level signal.
- `inputs`, input, `NUM_INPUTS` × `logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]`: class scores.
- `class_index`, output, `INDEX_WIDTH`: index of the maximum score.
- `max_value`, output, `signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]`: the maximum score.
- `outputs_ready`, output, 1: result valid. Held high until the next capture.
- `busy`, output, 1: high while a scan is in progress.

## Operation

- **States:**
  - `IDLE`: after reset, waiting for the first result.
  - `SCAN`: comparing one element per cycle.
  - `DONE`: result held.
- **Trigger:** a rising edge of `inputs_ready`, meaning high now and low at the previous edge.
  - The edge-detect register resets to 0, so `inputs_ready` high at the first edge after reset counts as a trigger.
- **Capture:** on a trigger in `IDLE` or `DONE`:
  - All `NUM_INPUTS` elements are copied into a snapshot register. Later changes on `inputs` do not affect the result.
  - The scan counter clears to 0.
  - The state moves to `SCAN`.
- **SCAN, element at counter `k`:**
  - If `k == 0`: load it unconditionally as the best value and set the best index to 0.
  - Otherwise: replace the best only if it is strictly greater, using signed fixed-point compare. Ties keep the lowest index.
  - If `k == NUM_INPUTS-1`, register `class_index` and `max_value` and go to `DONE`. Otherwise increment `k`.
- **Triggers while in `SCAN`** are ignored, with no queueing. The edge-detect register still updates, so a level still high at `DONE` does not retrigger.
- **Width rules:** comparison is the full signed compare of `INTEGER_WIDTH + FRACTION_WIDTH` bits. No saturation or rounding is applied. `max_value` is a bit-exact copy of the winning element.
- **Reset values:**
  - State `IDLE`.
  - `class_index` = 0, `max_value` = 0, `outputs_ready` = 0, `busy` = 0.
  - Snapshot and counter = 0.
  - Edge-detect register = 0.
- **Reset mid-scan:** returns to `IDLE` at that edge. No result is produced. The scan does not resume.

## Timing

- **Latency:** `outputs_ready` rises exactly `NUM_INPUTS` + 1 edges after the edge that sampled the trigger. This holds for all `NUM_INPUTS`, including 1.
  - Capture edge, then `NUM_INPUTS` scan edges.
  - The last scan edge registers the result and raises `outputs_ready`.
- **`busy`:** high from the capture edge until the edge on which `outputs_ready` rises. `busy` and `outputs_ready` are never high together.
- **Re-trigger from `DONE`:** a trigger in `DONE` drops `outputs_ready` at the capture edge. `class_index` and `max_value` hold their old values until the new result registers.
- **Throughput:** one classification per `NUM_INPUTS` + 1 cycles at most.

## Structure

- `INTEGER_WIDTH`, `FRACTION_WIDTH` and the fixed-point typedef come from the shared package (`include.svh`). This block adds no new package items.
- The `IDLE`/`SCAN`/`DONE` state enum is local to this module.
- Single module, no sub-modules. The compare-and-select is a few lines inline.

## Test plan

1. **Basic.** `NUM_INPUTS`=4, scores {0.25, 1.5, −2.0, 0.75}, `inputs_ready` raised and held.
   - Expect `class_index`=1, `max_value`=1.5, `outputs_ready` exactly 5 edges after the trigger.
   - With the level still held, no second capture.
2. **Ties and negatives.** Scores {−3.0, −1.0, −1.0, −2.5}.
   - Expect `class_index`=1 and `max_value`=−1.0, i.e. the lowest tied index and a correct signed compare.
3. **Snapshot isolation.**
   - Capture {0, 0, 0, 2.0}.
   - On the next cycle change `inputs` to {5.0, 0, 0, 0} and drop `inputs_ready` after 1 cycle.
   - Expect `class_index`=3 and `max_value`=2.0.
4. **Trigger during SCAN.** A second rising edge 2 cycles into the scan is ignored. The first result is reported on schedule and `busy` stays high throughout.
5. **Re-trigger from DONE.** A new edge while in `DONE`:
   - `outputs_ready` drops at the capture edge.
   - The new result appears `NUM_INPUTS` + 1 edges later.
   - Old outputs hold meanwhile.
6. **Reset.**
   - Drive `reset` low mid-scan: all outputs are 0 at the next edge and the state is `IDLE`.
   - `NUM_INPUTS`=1 with {−0.5}: `class_index`=0, `max_value`=−0.5, latency 2 edges.

Source files
------------

// File: rtl/argmax_classifier_pkg.sv
// Shared fixed-point number format used by the dense layers and the
// argmax classification stage.
package argmax_classifier_pkg;

    localparam int INTEGER_WIDTH = 8;
    localparam int FRACTION_WIDTH = 8;
    localparam int FIXED_WIDTH = INTEGER_WIDTH + FRACTION_WIDTH;

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

endpackage

// File: rtl/argmax_classifier.sv
// Snapshots the final layer's score vector on a rising inputs_ready and scans
// it one element per cycle, reporting the index and value of the largest score.
module argmax_classifier
    import argmax_classifier_pkg::*;
#(
    parameter int NUM_INPUTS = 10,
    parameter int INDEX_WIDTH = $clog2(NUM_INPUTS > 1 ? NUM_INPUTS : 2)
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        inputs_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] inputs [NUM_INPUTS],
    output logic [INDEX_WIDTH-1:0]                      class_index,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] max_value,
    output logic                                        outputs_ready,
    output logic                                        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_INPUTS - 1);

    state_t                 state_q, state_d;
    logic                   ready_prev_q, ready_prev_d;
    fixed_t                 snapshot_q [NUM_INPUTS];
    fixed_t                 snapshot_d [NUM_INPUTS];
    logic [INDEX_WIDTH-1:0] scan_cnt_q, scan_cnt_d;
    fixed_t                 best_value_q, best_value_d;
    logic [INDEX_WIDTH-1:0] best_index_q, best_index_d;
    logic [INDEX_WIDTH-1:0] class_index_q, class_index_d;
    fixed_t                 max_value_q, max_value_d;
    logic                   outputs_ready_q, outputs_ready_d;
    logic                   busy_q, busy_d;

    logic                   trigger;
    fixed_t                 element;
    logic                   take_element;
    fixed_t                 next_best_value;
    logic [INDEX_WIDTH-1:0] next_best_index;

    // Strict greater-than keeps the lowest index on ties; element 0 always seeds.
    always_comb begin
        trigger         = inputs_ready && !ready_prev_q;
        element         = snapshot_q[scan_cnt_q];
        take_element    = (scan_cnt_q == '0) || (element > best_value_q);
        next_best_value = take_element ? element : best_value_q;
        next_best_index = take_element ? scan_cnt_q : best_index_q;
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no branch of the case can infer a latch.
        state_d         = state_q;
        ready_prev_d    = inputs_ready;
        snapshot_d      = snapshot_q;
        scan_cnt_d      = scan_cnt_q;
        best_value_d    = best_value_q;
        best_index_d    = best_index_q;
        class_index_d   = class_index_q;
        max_value_d     = max_value_q;
        outputs_ready_d = outputs_ready_q;
        busy_d          = busy_q;

        case (state_q)
            IDLE, DONE: begin
                if (trigger) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        snapshot_d[i] = inputs[i];
                    end
                    scan_cnt_d      = '0;
                    outputs_ready_d = 1'b0;
                    busy_d          = 1'b1;
                    state_d         = SCAN;
                end
            end
            SCAN: begin
                best_value_d = next_best_value;
                best_index_d = next_best_index;
                if (scan_cnt_q == LAST_INDEX) begin
                    class_index_d   = next_best_index;
                    max_value_d     = next_best_value;
                    outputs_ready_d = 1'b1;
                    busy_d          = 1'b0;
                    state_d         = DONE;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            ready_prev_q <= 1'b0;
            // NOTE: the snapshot is a small flop array, not a RAM, so it resets with everything else.
            for (int i = 0; i < NUM_INPUTS; i++) begin
                snapshot_q[i] <= '0;
            end
            scan_cnt_q      <= '0;
            best_value_q    <= '0;
            best_index_q    <= '0;
            class_index_q   <= '0;
            max_value_q     <= '0;
            outputs_ready_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            ready_prev_q    <= ready_prev_d;
            snapshot_q      <= snapshot_d;
            scan_cnt_q      <= scan_cnt_d;
            best_value_q    <= best_value_d;
            best_index_q    <= best_index_d;
            class_index_q   <= class_index_d;
            max_value_q     <= max_value_d;
            outputs_ready_q <= outputs_ready_d;
            busy_q          <= busy_d;
        end
    end

    assign class_index   = class_index_q;
    assign max_value     = max_value_q;
    assign outputs_ready = outputs_ready_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed vector table, multi-cycle
// corner sequences, and random vectors against a plain argmax model.
module tb_argmax_classifier;

    localparam int N = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset;
    logic                inputs_ready;
    logic signed [15:0]  inputs [N];
    logic [1:0]          class_index;
    logic [15:0]         max_value;
    logic                outputs_ready;
    logic                busy;

    logic                reset_s;
    logic                ready_s;
    logic signed [15:0]  inputs_s [1];
    logic [0:0]          class_index_s;
    logic [15:0]         max_value_s;
    logic                outputs_ready_s;
    logic                busy_s;

    int checks = 0;
    int failures = 0;

    argmax_classifier #(.NUM_INPUTS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .inputs_ready (inputs_ready),
        .inputs       (inputs),
        .class_index  (class_index),
        .max_value    (max_value),
        .outputs_ready(outputs_ready),
        .busy         (busy)
    );

    argmax_classifier #(.NUM_INPUTS(1)) dut_single (
        .clock        (clock),
        .reset        (reset_s),
        .inputs_ready (ready_s),
        .inputs       (inputs_s),
        .class_index  (class_index_s),
        .max_value    (max_value_s),
        .outputs_ready(outputs_ready_s),
        .busy         (busy_s)
    );

    typedef struct packed {
        logic [N-1:0][15:0] scores;
        logic [1:0]         exp_idx;
        logic [15:0]        exp_val;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input logic [N-1:0][15:0] s);
        for (int i = 0; i < N; i++) inputs[i] = s[i];
    endtask

    // Reference: find the largest signed score, then the first index holding it.
    function automatic void ref_argmax(input logic [N-1:0][15:0] s, output int idx, output logic [15:0] val);
        int best;
        best = -32768;
        for (int i = 0; i < N; i++) if (int'($signed(s[i])) > best) best = int'($signed(s[i]));
        val = 16'(best);
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (s[i] == val) idx = i;
    endfunction

    task automatic run_and_check(input string name, input logic [N-1:0][15:0] s,
                                 input logic [31:0] exp_idx, input logic [15:0] exp_val);
        inputs_ready = 1'b0;
        step();
        apply(s);
        inputs_ready = 1'b1;
        step();
        check({name, " busy@capture"}, busy, 1);
        check({name, " ready@capture"}, outputs_ready, 0);
        for (int e = 2; e <= N; e++) begin
            step();
            check({name, " ready early"}, outputs_ready, 0);
            check({name, " busy scan"}, busy, 1);
        end
        step();
        check({name, " ready"}, outputs_ready, 1);
        check({name, " busy done"}, busy, 0);
        check({name, " index"}, class_index, exp_idx);
        check({name, " value"}, max_value, exp_val);
        repeat (N + 2) step();
        check({name, " held no recapture"}, {30'd0, outputs_ready, busy}, 32'b10);
    endtask

    always @(negedge clock) begin
        if (reset && busy && outputs_ready) begin
            checks++;
            failures++;
            $display("FAIL busy_ready_overlap: got busy=1 ready=1 expected not both");
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t table_v [6];
        logic [N-1:0][15:0] s;
        int ridx;
        logic [15:0] rval;

        table_v[0] = '{scores: {16'h00C0, 16'hFE00, 16'h0180, 16'h0040}, exp_idx: 2'd1, exp_val: 16'h0180};
        table_v[1] = '{scores: {16'hFD80, 16'hFF00, 16'hFF00, 16'hFD00}, exp_idx: 2'd1, exp_val: 16'hFF00};
        table_v[2] = '{scores: {16'h0000, 16'h7FFF, 16'h7FFF, 16'h8000}, exp_idx: 2'd1, exp_val: 16'h7FFF};
        table_v[3] = '{scores: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp_idx: 2'd0, exp_val: 16'h8000};
        table_v[4] = '{scores: {16'h0000, 16'h0001, 16'h0000, 16'hFFFF}, exp_idx: 2'd2, exp_val: 16'h0001};
        table_v[5] = '{scores: {16'h0300, 16'h0100, 16'h0200, 16'hFF00}, exp_idx: 2'd3, exp_val: 16'h0300};

        reset = 1'b0;
        reset_s = 1'b0;
        inputs_ready = 1'b0;
        ready_s = 1'b0;
        apply('0);
        inputs_s[0] = '0;
        step();
        step();
        check("reset index", class_index, 0);
        check("reset value", max_value, 0);
        check("reset ready", outputs_ready, 0);
        check("reset busy", busy, 0);
        check("reset single ready", outputs_ready_s, 0);
        reset = 1'b1;
        reset_s = 1'b1;
        step();
        check("idle no trigger", busy, 0);

        for (int v = 0; v < 6; v++) begin
            run_and_check($sformatf("table%0d", v), table_v[v].scores,
                          32'(table_v[v].exp_idx), table_v[v].exp_val);
        end

        // Snapshot isolation: inputs change right after capture.
        inputs_ready = 1'b0;
        step();
        apply({16'h0200, 16'h0000, 16'h0000, 16'h0000});
        inputs_ready = 1'b1;
        step();
        apply({16'h0000, 16'h0000, 16'h0000, 16'h0500});
        step();
        inputs_ready = 1'b0;
        repeat (N - 1) step();
        check("isolation ready", outputs_ready, 1);
        check("isolation index", class_index, 3);
        check("isolation value", max_value, 16'h0200);

        // Trigger during SCAN is ignored.
        inputs_ready = 1'b0;
        step();
        apply({16'h0080, 16'h0000, 16'h0300, 16'h0100});
        inputs_ready = 1'b1;
        step();
        apply({16'h0000, 16'h0700, 16'h0000, 16'h0000});
        step();
        check("scan trig busy2", busy, 1);
        inputs_ready = 1'b0;
        step();
        check("scan trig busy3", busy, 1);
        inputs_ready = 1'b1;
        step();
        check("scan trig busy4", busy, 1);
        check("scan trig ready4", outputs_ready, 0);
        step();
        check("scan trig ready", outputs_ready, 1);
        check("scan trig index", class_index, 1);
        check("scan trig value", max_value, 16'h0300);
        repeat (3) step();
        check("level held no retrigger", {30'd0, outputs_ready, busy}, 32'b10);

        // Re-trigger from DONE: old result held until the new one registers.
        inputs_ready = 1'b0;
        step();
        check("done held ready", outputs_ready, 1);
        apply({16'hFC00, 16'hFF80, 16'hFE00, 16'hFF00});
        inputs_ready = 1'b1;
        step();
        check("retrig ready drop", outputs_ready, 0);
        check("retrig busy", busy, 1);
        check("retrig old index", class_index, 1);
        check("retrig old value", max_value, 16'h0300);
        for (int e = 2; e <= N; e++) begin
            step();
            check("retrig hold index", class_index, 1);
            check("retrig hold value", max_value, 16'h0300);
        end
        step();
        check("retrig ready", outputs_ready, 1);
        check("retrig new index", class_index, 2);
        check("retrig new value", max_value, 16'hFF80);

        // Random vectors, biased towards ties and extreme values.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0: s[i] = 16'h0100;
                    1: s[i] = 16'hFF00;
                    2: s[i] = 16'h8000;
                    3: s[i] = 16'h7FFF;
                    default: s[i] = 16'($urandom());
                endcase
            end
            ref_argmax(s, ridx, rval);
            run_and_check($sformatf("rand%0d", it), s, 32'(ridx), rval);
        end

        // Reset mid-scan: everything clears and the scan does not resume.
        inputs_ready = 1'b0;
        step();
        apply({16'h0005, 16'h0030, 16'h0020, 16'h0010});
        inputs_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("midreset index", class_index, 0);
        check("midreset value", max_value, 0);
        check("midreset ready", outputs_ready, 0);
        check("midreset busy", busy, 0);
        inputs_ready = 1'b0;
        reset = 1'b1;
        repeat (N + 3) step();
        check("midreset no resume", {30'd0, outputs_ready, busy}, 0);
        check("midreset value stays", max_value, 0);

        // A level already high at the first edge after reset is a trigger.
        reset = 1'b0;
        inputs_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        check("post reset capture", busy, 1);
        repeat (N - 1) step();
        check("post reset early", outputs_ready, 0);
        step();
        check("post reset ready", outputs_ready, 1);
        check("post reset index", class_index, 2);
        check("post reset value", max_value, 16'h0030);

        // Single-element instance: two-edge latency.
        inputs_s[0] = 16'hFF80;
        ready_s = 1'b1;
        step();
        check("single busy", busy_s, 1);
        check("single ready early", outputs_ready_s, 0);
        step();
        check("single ready", outputs_ready_s, 1);
        check("single busy done", busy_s, 0);
        check("single index", class_index_s, 0);
        check("single value", max_value_s, 16'hFF80);
        ready_s = 1'b0;
        step();
        inputs_s[0] = 16'h7FFF;
        ready_s = 1'b1;
        step();
        check("single retrig drop", outputs_ready_s, 0);
        check("single retrig hold", max_value_s, 16'hFF80);
        step();
        check("single retrig ready", outputs_ready_s, 1);
        check("single retrig value", max_value_s, 16'h7FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
